// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_reg_ctrl                                                     |
// | Brief   : SPI-slave byte-stream register controller for fan duty/control. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spi_reg_ctrl #(
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter logic [7:0] DUTY_RESET = 8'h80
) (
    input  logic        sysclk,
    input  logic        iRstN,
    input  logic        iRxReady,
    input  logic [7:0]  iRx,
    input  logic        iSPICS,
    output logic        oTxReady,
    output logic [7:0]  oTx,
    input  logic [15:0] iTach,
    output logic [7:0]  oDuty,
    output logic [7:0]  oCtrl,
    output logic        oErr
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] RDATA = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0] state;
    logic [2:0] ptr;
    logic       rx_meta, rx_sync, rx_prev;
    logic       cs_meta, cs_sync, cs_prev;
    logic [7:0] duty, ctrl, scratch, errcnt, tach_hi;

    logic       rx_evt, cs_rise, cs_fall, cmd_bad;
    logic       load_en;
    logic [2:0] load_addr;
    logic [7:0] load_data;

    assign rx_evt  = rx_sync & ~rx_prev;
    assign cs_rise = cs_sync & ~cs_prev;
    assign cs_fall = ~cs_sync & cs_prev;
    assign cmd_bad = (iRx[6:3] != 4'd0);

    // A deselect in the same cycle as the byte suppresses the MISO load.
    always_comb begin
        load_en   = 1'b0;
        load_addr = ptr + 3'd1;
        if (rx_evt && !cs_rise) begin
            if (state == CMD && iRx[7] && !cmd_bad) begin
                load_en   = 1'b1;
                load_addr = iRx[2:0];
            end else if (state == RDATA) begin
                load_en = 1'b1;
            end
        end
    end

    always_comb begin
        load_data = 8'h00;
        case (load_addr)
            3'd0:    load_data = ID_VALUE;
            3'd1:    load_data = {6'b0, (iTach == 16'h0000), (state != IDLE)};
            3'd2:    load_data = duty;
            3'd3:    load_data = ctrl;
            3'd4:    load_data = iTach[7:0];
            3'd5:    load_data = tach_hi;
            3'd6:    load_data = scratch;
            default: load_data = errcnt;
        endcase
    end

    always_ff @(posedge sysclk or negedge iRstN) begin
        if (!iRstN) begin
            rx_meta  <= 1'b0;
            rx_sync  <= 1'b0;
            rx_prev  <= 1'b0;
            cs_meta  <= 1'b0;
            cs_sync  <= 1'b0;
            cs_prev  <= 1'b0;
            state    <= IDLE;
            ptr      <= 3'd0;
            oTxReady <= 1'b0;
            oTx      <= 8'h00;
            oErr     <= 1'b0;
            duty     <= DUTY_RESET;
            ctrl     <= 8'h00;
            scratch  <= 8'h00;
            errcnt   <= 8'h00;
            tach_hi  <= 8'h00;
        end else begin
            rx_meta  <= iRxReady;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            cs_meta  <= iSPICS;
            cs_sync  <= cs_meta;
            cs_prev  <= cs_sync;
            oTxReady <= 1'b0;
            oErr     <= 1'b0;

            if (load_en) begin
                oTx      <= load_data;
                oTxReady <= 1'b1;
                if (load_addr == 3'd4) begin
                    tach_hi <= iTach[15:8];
                end
            end

            case (state)
                IDLE: begin
                    ptr <= 3'd0;
                    if (cs_fall) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (rx_evt) begin
                        ptr <= iRx[2:0];
                        if (cmd_bad) begin
                            state <= DRAIN;
                            oErr  <= 1'b1;
                            if (errcnt != 8'hFF) begin
                                errcnt <= errcnt + 8'd1;
                            end
                        end else if (iRx[7]) begin
                            state <= RDATA;
                        end else begin
                            state <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (rx_evt) begin
                        case (ptr)
                            3'd2:    duty    <= iRx;
                            3'd3:    ctrl    <= iRx;
                            3'd6:    scratch <= iRx;
                            default: ;
                        endcase
                        ptr <= ptr + 3'd1;
                    end
                end
                RDATA: begin
                    if (rx_evt) begin
                        ptr <= ptr + 3'd1;
                    end
                end
                DRAIN:   ;
                default: state <= IDLE;
            endcase

            // Deselect wins over the case above but after the byte was applied.
            if (cs_rise) begin
                state <= IDLE;
                ptr   <= 3'd0;
            end
        end
    end

    assign oDuty = duty;
    assign oCtrl = ctrl;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spi_reg_ctrl                                                  |
// | Brief   : Frame-level reference model bench for spi_reg_ctrl.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spi_reg_ctrl;

    logic        sysclk = 1'b0;
    logic        iRstN = 1'b0;
    logic        iRxReady = 1'b0;
    logic [7:0]  iRx = 8'h00;
    logic        iSPICS = 1'b1;
    logic        oTxReady;
    logic [7:0]  oTx;
    logic [15:0] iTach = 16'h1234;
    logic [7:0]  oDuty, oCtrl;
    logic        oErr;

    spi_reg_ctrl #(.ID_VALUE(8'hA5), .DUTY_RESET(8'h80)) dut (
        .sysclk(sysclk), .iRstN(iRstN), .iRxReady(iRxReady), .iRx(iRx),
        .iSPICS(iSPICS), .oTxReady(oTxReady), .oTx(oTx), .iTach(iTach),
        .oDuty(oDuty), .oCtrl(oCtrl), .oErr(oErr)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference model: plain register array with pointer arithmetic.
    logic [7:0] m_reg [0:7];
    logic [7:0] m_tachhi;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_reg[0] = 8'hA5;
        m_reg[2] = 8'h80;
        m_tachhi = 8'h00;
    endtask

    function automatic logic [7:0] m_read(input int a);
        case (a)
            1:       return {6'b0, (iTach == 16'h0000), 1'b1};
            4:       return iTach[7:0];
            5:       return m_tachhi;
            default: return m_reg[a];
        endcase
    endfunction

    // Output monitor, sampled on the falling edge.
    logic [7:0] tx_q[$];
    int         err_seen = 0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_tx = 8'h00;
    logic       prev_rst = 1'b0;

    always @(negedge sysclk) begin
        if (iRstN && prev_rst) begin
            if (oTxReady) tx_q.push_back(oTx);
            if (oErr) err_seen++;
            if (oTxReady && prev_ready) check_eq("ready_one_cycle", {prev_ready, oTxReady}, 2'b01);
            if (oTx !== prev_tx) check_eq("tx_change_on_ready", {oTxReady, prev_ready}, 2'b10);
        end
        prev_ready = oTxReady;
        prev_tx    = oTx;
        prev_rst   = iRstN;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic cs_low();
        iSPICS = 1'b0;
        cyc(5);
    endtask

    task automatic cs_high();
        iSPICS = 1'b1;
        cyc(5);
    endtask

    // Any MISO load must land while the byte is still presented.
    task automatic send_byte(input logic [7:0] b);
        int n_hi;
        iRx = b;
        iRxReady = 1'b1;
        cyc(6);
        n_hi = tx_q.size();
        iRxReady = 1'b0;
        cyc(4);
        check_eq("tx_latency", tx_q.size(), n_hi);
    endtask

    logic [7:0]  frame_q[$];
    bit          tach_mid_en = 1'b0;
    logic [15:0] tach_mid = 16'h0000;

    task automatic run_frame(input string tag);
        logic [7:0] exp_q[$];
        logic [7:0] cmd;
        int         exp_err;
        int         a;
        exp_err = 0;
        cmd = frame_q[0];
        tx_q.delete();
        err_seen = 0;
        cs_low();
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == 1 && tach_mid_en) iTach = tach_mid;
            if (cmd[6:3] != 4'd0) begin
                if (i == 0) begin
                    exp_err++;
                    if (m_reg[7] != 8'hFF) m_reg[7] = m_reg[7] + 8'd1;
                end
            end else if (cmd[7]) begin
                a = (int'(cmd[2:0]) + i) % 8;
                exp_q.push_back(m_read(a));
                if (a == 4) m_tachhi = iTach[15:8];
            end else if (i > 0) begin
                a = (int'(cmd[2:0]) + i - 1) % 8;
                if (a == 2 || a == 3 || a == 6) m_reg[a] = frame_q[i];
            end
            send_byte(frame_q[i]);
        end
        cs_high();
        tach_mid_en = 1'b0;
        check_eq({tag, "_txcount"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            check_eq({tag, "_tx"}, tx_q[i], exp_q[i]);
        check_eq({tag, "_err"}, err_seen, exp_err);
        check_eq({tag, "_duty"}, oDuty, m_reg[2]);
        check_eq({tag, "_ctrl"}, oCtrl, m_reg[3]);
    endtask

    initial begin
        m_reset();
        cyc(3);
        check_eq("rst_txready", oTxReady, 1'b0);
        check_eq("rst_tx", oTx, 8'h00);
        check_eq("rst_err", oErr, 1'b0);
        check_eq("rst_duty", oDuty, 8'h80);
        check_eq("rst_ctrl", oCtrl, 8'h00);
        iRstN = 1'b1;
        cyc(6);

        // Write burst
        frame_q = '{8'h02, 8'h40, 8'h03};
        run_frame("wr_burst");
        check_eq("wr_burst_duty_abs", oDuty, 8'h40);
        check_eq("wr_burst_ctrl_abs", oCtrl, 8'h03);

        // Read burst
        frame_q = '{8'h80, 8'h00, 8'h00};
        run_frame("rd_burst");
        check_eq("rd_burst_id", tx_q[0], 8'hA5);
        check_eq("rd_burst_status", tx_q[1], 8'h01);
        check_eq("rd_burst_duty", tx_q[2], 8'h40);

        // Wrap through read-only registers
        frame_q = '{8'h06, 8'h11, 8'h22, 8'h33};
        run_frame("wrap_wr");
        frame_q = '{8'h86, 8'h00, 8'h00};
        run_frame("wrap_rd");
        check_eq("wrap_scratch", tx_q[0], 8'h11);
        check_eq("wrap_errcnt", tx_q[1], 8'h00);
        check_eq("wrap_id", tx_q[2], 8'hA5);

        // Bad command
        frame_q = '{8'h18, 8'hFF};
        run_frame("bad_cmd");
        check_eq("bad_cmd_err_abs", err_seen, 1);
        check_eq("bad_cmd_duty_abs", oDuty, 8'h40);
        frame_q = '{8'h87, 8'h00};
        run_frame("errcnt_rd");
        check_eq("errcnt_abs", tx_q[0], 8'h01);

        // Tach snapshot held across an iTach change
        iTach = 16'h1234;
        tach_mid = 16'hBEEF;
        tach_mid_en = 1'b1;
        frame_q = '{8'h84, 8'h00};
        run_frame("tach");
        check_eq("tach_lo_abs", tx_q[0], 8'h34);
        check_eq("tach_hi_abs", tx_q[1], 8'h12);

        // Deselect coincident with a write byte
        tx_q.delete();
        cs_low();
        send_byte(8'h02);
        iRx = 8'h55;
        iRxReady = 1'b1;
        iSPICS = 1'b1;
        cyc(6);
        iRxReady = 1'b0;
        cyc(4);
        m_reg[2] = 8'h55;
        send_byte(8'h77);
        check_eq("coinc_duty", oDuty, 8'h55);
        check_eq("coinc_idle_ctrl", oCtrl, m_reg[3]);
        check_eq("coinc_no_tx", tx_q.size(), 0);

        // Reset in the middle of a burst
        cs_low();
        send_byte(8'h02);
        send_byte(8'h11);
        check_eq("midrst_pre_duty", oDuty, 8'h11);
        iRx = 8'h22;
        iRxReady = 1'b1;
        cyc(1);
        iRstN = 1'b0;
        cyc(3);
        check_eq("midrst_duty", oDuty, 8'h80);
        check_eq("midrst_ctrl", oCtrl, 8'h00);
        check_eq("midrst_tx", oTx, 8'h00);
        check_eq("midrst_txready", oTxReady, 1'b0);
        m_reset();
        iRxReady = 1'b0;
        iRstN = 1'b1;
        cyc(6);
        tx_q.delete();
        send_byte(8'h80);
        check_eq("midrst_wait_cs_fall", tx_q.size(), 0);
        check_eq("midrst_post_duty", oDuty, 8'h80);
        cs_high();
        frame_q = '{8'h85, 8'h00, 8'h00};
        run_frame("midrst_rd");
        check_eq("midrst_tachhi", tx_q[0], 8'h00);
        check_eq("midrst_scratch", tx_q[1], 8'h00);
        check_eq("midrst_errcnt", tx_q[2], 8'h00);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            int nb;
            iTach = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            cmd = 8'($urandom);
            if ($urandom_range(0, 4) != 0) cmd[6:3] = 4'd0;
            nb = $urandom_range(0, 4);
            frame_q.delete();
            frame_q.push_back(cmd);
            for (int k = 0; k < nb; k++) frame_q.push_back(8'($urandom));
            run_frame("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
